// File: rtl/c5x72_feeder.sv
// c5x72_feeder: assembles 35 streamed samples into a 5x7 window and issues it to the c5x72 core.
module c5x72_feeder #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_in,
  input  logic [W-1:0] din,
  input  logic         sof,
  output logic         stop_in,
  input  logic         hold,
  output logic         push_samp,
  output logic         err_sof,
  output logic [15:0]  win_cnt,
  output logic [W-1:0] samp00, samp01, samp02, samp03, samp04,
  output logic [W-1:0] samp10, samp11, samp12, samp13, samp14,
  output logic [W-1:0] samp20, samp21, samp22, samp23, samp24,
  output logic [W-1:0] samp30, samp31, samp32, samp33, samp34,
  output logic [W-1:0] samp40, samp41, samp42, samp43, samp44,
  output logic [W-1:0] samp50, samp51, samp52, samp53, samp54,
  output logic [W-1:0] samp60, samp61, samp62, samp63, samp64
);
  typedef enum logic {FILL, READY} state_t;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [W-1:0] fill_q [35];
  logic [W-1:0] fill_d [35];
  logic [W-1:0] out_q [35];
  logic [W-1:0] out_d [35];
  logic push_samp_q, push_samp_d, err_sof_q, err_sof_d;
  logic [15:0] win_cnt_q, win_cnt_d;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fill_d = fill_q;
    out_d = out_q;
    push_samp_d = 1'b0;
    err_sof_d = 1'b0;
    win_cnt_d = win_cnt_q;
    if (push_in && state_q == FILL) begin
      fill_d[sof ? 6'd0 : idx_q] = din;
      idx_d = sof ? 6'd1 : (idx_q == 6'd34 ? 6'd0 : idx_q + 6'd1);
      err_sof_d = sof && idx_q != 6'd0;
      state_d = (!sof && idx_q == 6'd34) ? READY : FILL;
    end
    // issue: the bubble cycle spent in READY is the only gap between windows
    if (state_q == READY && !hold) begin
      out_d = fill_q;
      push_samp_d = 1'b1;
      win_cnt_d = win_cnt_q + 16'd1;
      state_d = FILL;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q <= 6'd0;
      out_q <= '{default: '0};
      push_samp_q <= 1'b0;
      err_sof_q <= 1'b0;
      win_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      out_q <= out_d;
      push_samp_q <= push_samp_d;
      err_sof_q <= err_sof_d;
      win_cnt_q <= win_cnt_d;
    end
  end
  always_ff @(posedge clk) fill_q <= fill_d;
  assign stop_in = state_q == READY;
  assign push_samp = push_samp_q;
  assign err_sof = err_sof_q;
  assign win_cnt = win_cnt_q;
  assign samp00 = out_q[0];  assign samp01 = out_q[1];  assign samp02 = out_q[2];
  assign samp03 = out_q[3];  assign samp04 = out_q[4];
  assign samp10 = out_q[5];  assign samp11 = out_q[6];  assign samp12 = out_q[7];
  assign samp13 = out_q[8];  assign samp14 = out_q[9];
  assign samp20 = out_q[10]; assign samp21 = out_q[11]; assign samp22 = out_q[12];
  assign samp23 = out_q[13]; assign samp24 = out_q[14];
  assign samp30 = out_q[15]; assign samp31 = out_q[16]; assign samp32 = out_q[17];
  assign samp33 = out_q[18]; assign samp34 = out_q[19];
  assign samp40 = out_q[20]; assign samp41 = out_q[21]; assign samp42 = out_q[22];
  assign samp43 = out_q[23]; assign samp44 = out_q[24];
  assign samp50 = out_q[25]; assign samp51 = out_q[26]; assign samp52 = out_q[27];
  assign samp53 = out_q[28]; assign samp54 = out_q[29];
  assign samp60 = out_q[30]; assign samp61 = out_q[31]; assign samp62 = out_q[32];
  assign samp63 = out_q[33]; assign samp64 = out_q[34];
endmodule

// File: tb/tb_c5x72_feeder.sv
// tb_c5x72_feeder: scoreboard bench for c5x72_feeder; a fill model queues expected windows.
module tb_c5x72_feeder;
  localparam int W = 40;
  localparam int WV = 35 * W;
  logic clk = 1'b0;
  logic reset = 1'b1, push_in = 1'b0, sof = 1'b0, hold = 1'b0;
  logic [W-1:0] din = '0;
  logic stop_in, push_samp, err_sof;
  logic [15:0] win_cnt;
  logic [W-1:0] s [35];
  logic [WV-1:0] samp_v;
  int n_cmp = 0, n_fail = 0, n_push = 0, n_err = 0, exp_err = 0, cyc = 0;
  int m_idx = 0, m_win = 0;
  logic [WV-1:0] m_fill = '0;
  logic [WV-1:0] sb [$];
  int push_cyc [$];
  logic [WV-1:0] last_v = '0;
  logic prev_push = 1'b0;

  c5x72_feeder #(.W(W)) dut (
    .clk(clk), .reset(reset), .push_in(push_in), .din(din), .sof(sof),
    .stop_in(stop_in), .hold(hold), .push_samp(push_samp), .err_sof(err_sof), .win_cnt(win_cnt),
    .samp00(s[0]),  .samp01(s[1]),  .samp02(s[2]),  .samp03(s[3]),  .samp04(s[4]),
    .samp10(s[5]),  .samp11(s[6]),  .samp12(s[7]),  .samp13(s[8]),  .samp14(s[9]),
    .samp20(s[10]), .samp21(s[11]), .samp22(s[12]), .samp23(s[13]), .samp24(s[14]),
    .samp30(s[15]), .samp31(s[16]), .samp32(s[17]), .samp33(s[18]), .samp34(s[19]),
    .samp40(s[20]), .samp41(s[21]), .samp42(s[22]), .samp43(s[23]), .samp44(s[24]),
    .samp50(s[25]), .samp51(s[26]), .samp52(s[27]), .samp53(s[28]), .samp54(s[29]),
    .samp60(s[30]), .samp61(s[31]), .samp62(s[32]), .samp63(s[33]), .samp64(s[34])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always_comb begin
    samp_v = '0;
    for (int i = 0; i < 35; i++) samp_v[i*W +: W] = s[i];
  end

  // scoreboard monitor: every issued window is popped and compared bit-exact
  always @(negedge clk) begin
    logic [WV-1:0] e;
    if (reset) begin
      last_v = samp_v;
      prev_push = 1'b0;
    end else begin
      n_cmp++;
      if ($isunknown({stop_in, push_samp, err_sof, win_cnt, samp_v})) begin
        n_fail++; $display("FAIL x_on_outputs at cycle %0d", cyc);
      end
      if (push_samp) begin
        push_cyc.push_back(cyc);
        n_push++;
        n_cmp++;
        if (prev_push) begin
          n_fail++; $display("FAIL push_width: push_samp high two cycles at cycle %0d", cyc);
        end
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL unexpected_push at cycle %0d: got push, required none", cyc);
        end else begin
          e = sb.pop_front();
          if (samp_v !== e) begin
            n_fail++;
            for (int i = 0; i < 35; i++)
              if (samp_v[i*W +: W] !== e[i*W +: W]) begin
                $display("FAIL window word %0d: got %h required %h", i, samp_v[i*W +: W], e[i*W +: W]);
                break;
              end
          end
        end
        last_v = samp_v;
      end else if (samp_v !== last_v) begin
        n_fail++; $display("FAIL samp_changed without push at cycle %0d", cyc);
      end
      if (err_sof) n_err++;
      prev_push = push_samp;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_win = 0;
    sb.delete();
  endtask

  task automatic send(input logic [W-1:0] d, input logic f);
    int t;
    push_in = 1'b1; din = d; sof = f;
    t = 0;
    while (stop_in && t < 100) begin tick(); t++; end
    if (stop_in) begin
      n_cmp++; n_fail++; $display("FAIL send_timeout: stop_in stuck at 1, required 0");
    end
    if (f) begin
      if (m_idx != 0) exp_err++;
      m_fill[0 +: W] = d;
      m_idx = 1;
    end else begin
      m_fill[m_idx*W +: W] = d;
      if (m_idx == 34) begin sb.push_back(m_fill); m_idx = 0; m_win++; end
      else m_idx++;
    end
    tick();
    sof = 1'b0;
  endtask

  task automatic wait_push();
    int t;
    t = 0;
    while (!push_samp && t < 50) begin tick(); t++; end
    n_cmp++;
    if (!push_samp) begin n_fail++; $display("FAIL push_timeout: push_samp got 0 required 1"); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    n_cmp++;
    if ({stop_in, push_samp, err_sof} !== 3'b000 || win_cnt !== 16'd0 || samp_v !== '0) begin
      n_fail++;
      $display("FAIL reset_state: stop=%b push=%b err=%b win=%0d samp_nonzero=%b, required all 0",
               stop_in, push_samp, err_sof, win_cnt, samp_v != '0);
    end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 35; i++) send(W'(i), 1'b0);
    push_in = 1'b0;
    n_cmp++;
    if (stop_in !== 1'b1) begin n_fail++; $display("FAIL basic_stop_in: got %b required 1", stop_in); end
    tick();
    n_cmp++;
    if (push_samp !== 1'b1 || stop_in !== 1'b0) begin
      n_fail++; $display("FAIL basic_latency: push=%b stop=%b required push=1 stop=0", push_samp, stop_in);
    end
    n_cmp++;
    if (s[0] !== 40'd1 || s[4] !== 40'd5 || s[5] !== 40'd6 || s[34] !== 40'd35) begin
      n_fail++; $display("FAIL basic_values: samp00=%0d samp04=%0d samp10=%0d samp64=%0d required 1 5 6 35",
                         s[0], s[4], s[5], s[34]);
    end
    n_cmp++;
    if (win_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_win_cnt: got %0d required 1", win_cnt); end
    tick();
    n_cmp++;
    if (push_samp !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: push_samp got 1 required 0"); end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    for (int i = 0; i < 35; i++) send(W'(100 + i), 1'b0);
    for (int c = 0; c < 10; c++) begin
      push_in = 1'b1; din = 40'd99;
      n_cmp++;
      if (stop_in !== 1'b1 || push_samp !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle %0d: stop=%b push=%b required stop=1 push=0", c, stop_in, push_samp);
      end
      tick();
    end
    hold = 1'b0; push_in = 1'b0;
    tick();
    n_cmp++;
    if (push_samp !== 1'b1 || s[0] !== 40'd100 || s[34] !== 40'd134 || win_cnt !== 16'd2) begin
      n_fail++; $display("FAIL hold_release: push=%b samp00=%0d samp64=%0d win=%0d required 1 100 134 2",
                         push_samp, s[0], s[34], win_cnt);
    end
    tick();
  endtask

  task automatic test_sof();
    for (int i = 0; i < 12; i++) send(W'(200 + i), 1'b0);
    send(40'h7F, 1'b1);
    push_in = 1'b0;
    n_cmp++;
    if (err_sof !== 1'b1) begin n_fail++; $display("FAIL sof_err: err_sof got %b required 1", err_sof); end
    tick();
    n_cmp++;
    if (err_sof !== 1'b0) begin n_fail++; $display("FAIL sof_err_width: err_sof got %b required 0", err_sof); end
    for (int i = 0; i < 34; i++) send(W'(300 + i), 1'b0);
    push_in = 1'b0;
    wait_push();
    n_cmp++;
    if (s[0] !== 40'h7F || s[1] !== 40'd300) begin
      n_fail++; $display("FAIL sof_window: samp00=%h samp01=%0d required 7f 300", s[0], s[1]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    push_cyc.delete();
    for (int i = 0; i < 70; i++) send(W'(i), 1'b0);
    push_in = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (push_cyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_pushes: got %0d pushes required 2", push_cyc.size());
    end else if (push_cyc[1] - push_cyc[0] != 36) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles required 36", push_cyc[1] - push_cyc[0]);
    end
    n_cmp++;
    if (s[0] !== 40'd35 || s[34] !== 40'd69) begin
      n_fail++; $display("FAIL b2b_second: samp00=%0d samp64=%0d required 35 69", s[0], s[34]);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    for (int i = 0; i < 20; i++) send(W'(500 + i), 1'b0);
    push_in = 1'b0;
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    model_reset();
    n_cmp++;
    if (stop_in !== 1'b0 || win_cnt !== 16'd0 || samp_v !== '0 || push_samp !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_fill: stop=%b win=%0d push=%b required 0 0 0", stop_in, win_cnt, push_samp);
    end
    hold = 1'b1;
    for (int i = 0; i < 35; i++) send(W'(600 + i), 1'b0);
    push_in = 1'b0;
    tick();
    n_cmp++;
    if (stop_in !== 1'b1) begin n_fail++; $display("FAIL reset_ready_pre: stop_in got %b required 1", stop_in); end
    reset = 1'b1; tick(); reset = 1'b0; hold = 1'b0;
    model_reset();
    n0 = n_push;
    n_cmp++;
    if (stop_in !== 1'b0 || push_samp !== 1'b0 || win_cnt !== 16'd0 || samp_v !== '0) begin
      n_fail++; $display("FAIL reset_ready: stop=%b push=%b win=%0d required 0 0 0", stop_in, push_samp, win_cnt);
    end
    repeat (5) tick();
    n_cmp++;
    if (n_push != n0) begin n_fail++; $display("FAIL reset_ready_push: got %0d pushes required 0", n_push - n0); end
    for (int i = 0; i < 35; i++) send(W'(700 + i), 1'b0);
    push_in = 1'b0;
    wait_push();
    n_cmp++;
    if (win_cnt !== 16'd1 || s[0] !== 40'd700) begin
      n_fail++; $display("FAIL reset_clean: win=%0d samp00=%0d required 1 700", win_cnt, s[0]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    for (int i = 0; i < 105; i++) begin
      case ($urandom_range(0, 3))
        0: d = 40'hFF_FFFF_FFFF;
        1: d = 40'h80_0000_0000;
        default: d = {8'hFF, 32'($urandom)};
      endcase
      push_in = 1'b0;
      hold = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) tick();
      hold = 1'b0;
      send(d, 1'b0);
    end
    push_in = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (sb.size() != 0 || win_cnt !== 16'(m_win)) begin
      n_fail++; $display("FAIL random_drain: pending=%0d win=%0d required 0 %0d", sb.size(), win_cnt, m_win);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_sof();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++;
    if (n_err != exp_err) begin n_fail++; $display("FAIL err_sof_count: got %0d required %0d", n_err, exp_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
